// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        REDIRECT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, builds IF/ID and carries PC/prediction bits to stage 3.
module fetch_pc_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_stall,
    input  logic             hazard_stall,
    input  logic [31:0]      icache_rdata,
    input  logic [31:0]      btb_branch_pc,
    input  logic             btb_flush,
    input  logic             btb_taken,
    output logic [31:0]      icache_addr,
    output logic             icache_req,
    output logic [31:0]      pc_1,
    output logic [31:0]      instr_1,
    output logic             valid_1,
    output logic [7:0]       pc_3,
    output logic             pred_taken_3,
    output logic             valid_3,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] pred_cnt
);

    fetch_state_t state;
    logic [31:0]  pc_r;
    logic [31:0]  pending_pc;
    logic [31:0]  pc_next;
    logic [7:0]   pc_2;
    logic         valid_2;
    logic         pred_taken_2;

    logic in_redirect;
    logic redirect_now;
    logic flush_now;
    logic run_now;
    logic pred_now;
    logic squash_all;

    always_comb begin
        in_redirect  = (state == REDIRECT);
        flush_now    = btb_flush & ~icache_stall;
        redirect_now = in_redirect & ~icache_stall & ~btb_flush;
        run_now      = ~icache_stall & ~in_redirect & ~btb_flush & ~hazard_stall;
        // A zero target from the BTB is a miss, not a prediction.
        pred_now     = run_now & btb_taken & valid_1 & (btb_branch_pc != '0);
        squash_all   = btb_flush | (in_redirect & ~icache_stall);

        if (flush_now) begin
            pc_next = btb_branch_pc;
        end else if (redirect_now) begin
            pc_next = pending_pc;
        end else if (icache_stall || hazard_stall) begin
            pc_next = pc_r;
        end else if (pred_now) begin
            pc_next = btb_branch_pc;
        end else begin
            pc_next = pc_r + PC_STEP;
        end
    end

    assign icache_addr = pc_r;
    assign icache_req  = ~in_redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            pc_r       <= RESET_PC;
            pending_pc <= '0;
        end else begin
            pc_r <= pc_next;
            case (state)
                RUN, HOLD: begin
                    if (icache_stall && btb_flush) begin
                        state      <= REDIRECT;
                        pending_pc <= btb_branch_pc;
                    end else if (icache_stall) begin
                        state <= HOLD;
                    end else begin
                        state <= RUN;
                    end
                end
                REDIRECT: begin
                    // Latest flush during the stall wins.
                    if (icache_stall && btb_flush) begin
                        pending_pc <= btb_branch_pc;
                    end else if (!icache_stall) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_1         <= '0;
            instr_1      <= NOP_INSTR;
            valid_1      <= 1'b0;
            pc_2         <= '0;
            valid_2      <= 1'b0;
            pred_taken_2 <= 1'b0;
            pc_3         <= '0;
            valid_3      <= 1'b0;
            pred_taken_3 <= 1'b0;
        end else if (squash_all) begin
            instr_1      <= NOP_INSTR;
            valid_1      <= 1'b0;
            valid_2      <= 1'b0;
            pred_taken_2 <= 1'b0;
            valid_3      <= 1'b0;
            pred_taken_3 <= 1'b0;
        end else if (!icache_stall) begin
            pc_3         <= pc_2;
            valid_3      <= valid_2;
            pred_taken_3 <= pred_taken_2;
            if (hazard_stall) begin
                valid_2      <= 1'b0;
                pred_taken_2 <= 1'b0;
            end else begin
                pc_2         <= pc_1[7:0];
                valid_2      <= valid_1;
                pred_taken_2 <= pred_now;
                pc_1         <= pc_r;
                // The sequential fetch behind a taken prediction is wrong-path.
                instr_1      <= pred_now ? NOP_INSTR : icache_rdata;
                valid_1      <= ~pred_now;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (flush_now | redirect_now),
        .clr  (1'b0),
        .cnt  (flush_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_pred_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (pred_now),
        .clr  (1'b0),
        .cnt  (pred_cnt)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit, plus stalled-redirect and reset sequences.
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        icache_stall;
    logic        hazard_stall;
    logic [31:0] icache_rdata;
    logic [31:0] btb_branch_pc;
    logic        btb_flush;
    logic        btb_taken;
    logic [31:0] icache_addr;
    logic        icache_req;
    logic [31:0] pc_1;
    logic [31:0] instr_1;
    logic        valid_1;
    logic [7:0]  pc_3;
    logic        pred_taken_3;
    logic        valid_3;
    logic [15:0] flush_cnt;
    logic [15:0] pred_cnt;

    int total = 0;
    int bad   = 0;

    fetch_pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_stall (icache_stall),
        .hazard_stall (hazard_stall),
        .icache_rdata (icache_rdata),
        .btb_branch_pc(btb_branch_pc),
        .btb_flush    (btb_flush),
        .btb_taken    (btb_taken),
        .icache_addr  (icache_addr),
        .icache_req   (icache_req),
        .pc_1         (pc_1),
        .instr_1      (instr_1),
        .valid_1      (valid_1),
        .pc_3         (pc_3),
        .pred_taken_3 (pred_taken_3),
        .valid_3      (valid_3),
        .flush_cnt    (flush_cnt),
        .pred_cnt     (pred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {icache_stall, hazard_stall, btb_flush, btb_taken}; flg = {valid_1, valid_3, pred_taken_3, req}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] pc1;
        logic [7:0]  pc3;
        logic [3:0]  flg;
        logic [15:0] fc;
        logic [15:0] pcn;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] tgt,
                                input logic [31:0] addr, input logic [31:0] pc1,
                                input logic [7:0] pc3, input logic [3:0] flg,
                                input logic [15:0] fc, input logic [15:0] pcn);
        vec_t v;
        v.ctl = ctl; v.tgt = tgt; v.addr = addr; v.pc1 = pc1;
        v.pc3 = pc3; v.flg = flg; v.fc = fc; v.pcn = pcn;
        return v;
    endfunction

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [31:0] tgt);
        {icache_stall, hazard_stall, btb_flush, btb_taken} = ctl;
        btb_branch_pc = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        icache_rdata = rom(icache_addr);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " addr"}, icache_addr, 32'h0);
        check({tag, " req"}, 32'(icache_req), 32'd1);
        check({tag, " valid_1"}, 32'(valid_1), 32'd0);
        check({tag, " instr_1"}, instr_1, NOP);
        check({tag, " pc_1"}, pc_1, 32'h0);
        check({tag, " pc_3"}, 32'(pc_3), 32'h0);
        check({tag, " pred_taken_3"}, 32'(pred_taken_3), 32'd0);
        check({tag, " valid_3"}, 32'(valid_3), 32'd0);
        check({tag, " flush_cnt"}, 32'(flush_cnt), 32'd0);
        check({tag, " pred_cnt"}, 32'(pred_cnt), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(4'b0000, 32'h0, 32'h4, 32'h0, 8'h00, 4'b1001, 16'd0, 16'd0);
        vecs[1]  = mk(4'b0000, 32'h0, 32'h8, 32'h4, 8'h00, 4'b1001, 16'd0, 16'd0);
        vecs[2]  = mk(4'b0000, 32'h0, 32'hC, 32'h8, 8'h00, 4'b1101, 16'd0, 16'd0);
        vecs[3]  = mk(4'b0000, 32'h0, 32'h10, 32'hC, 8'h04, 4'b1101, 16'd0, 16'd0);
        // BTB miss: taken with zero target falls through
        vecs[4]  = mk(4'b0001, 32'h0, 32'h14, 32'h10, 8'h08, 4'b1101, 16'd0, 16'd0);
        vecs[5]  = mk(4'b0000, 32'h0, 32'h18, 32'h14, 8'h0C, 4'b1101, 16'd0, 16'd0);
        vecs[6]  = mk(4'b0000, 32'h0, 32'h1C, 32'h18, 8'h10, 4'b1101, 16'd0, 16'd0);
        vecs[7]  = mk(4'b0000, 32'h0, 32'h20, 32'h1C, 8'h14, 4'b1101, 16'd0, 16'd0);
        vecs[8]  = mk(4'b0000, 32'h0, 32'h24, 32'h20, 8'h18, 4'b1101, 16'd0, 16'd0);
        // predicted taken from pc_1 = 0x20 to 0x80
        vecs[9]  = mk(4'b0001, 32'h80, 32'h80, 32'h0, 8'h1C, 4'b0101, 16'd0, 16'd1);
        vecs[10] = mk(4'b0000, 32'h0, 32'h84, 32'h80, 8'h20, 4'b1111, 16'd0, 16'd1);
        vecs[11] = mk(4'b0000, 32'h0, 32'h88, 32'h84, 8'h00, 4'b1001, 16'd0, 16'd1);
        // flush together with taken: flush wins
        vecs[12] = mk(4'b0011, 32'h40, 32'h40, 32'h0, 8'h00, 4'b0001, 16'd1, 16'd1);
        vecs[13] = mk(4'b0000, 32'h0, 32'h44, 32'h40, 8'h00, 4'b1001, 16'd1, 16'd1);
        vecs[14] = mk(4'b0000, 32'h0, 32'h48, 32'h44, 8'h00, 4'b1001, 16'd1, 16'd1);
        vecs[15] = mk(4'b0000, 32'h0, 32'h4C, 32'h48, 8'h40, 4'b1101, 16'd1, 16'd1);
        // hazard stall ignores a prediction and bubbles stage 2
        vecs[16] = mk(4'b0101, 32'h90, 32'h4C, 32'h48, 8'h44, 4'b1101, 16'd1, 16'd1);
        vecs[17] = mk(4'b0100, 32'h0, 32'h4C, 32'h48, 8'h00, 4'b1001, 16'd1, 16'd1);
        vecs[18] = mk(4'b0000, 32'h0, 32'h50, 32'h4C, 8'h00, 4'b1001, 16'd1, 16'd1);
        // flush during hazard stall applies at once
        vecs[19] = mk(4'b0110, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0, 8'h00, 4'b0001, 16'd2, 16'd1);
        vecs[20] = mk(4'b0000, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 8'h00, 4'b1001, 16'd2, 16'd1);
        vecs[21] = mk(4'b0000, 32'h0, 32'h0, 32'hFFFF_FFFC, 8'h00, 4'b1001, 16'd2, 16'd1);
        vecs[22] = mk(4'b0000, 32'h0, 32'h4, 32'h0, 8'hF8, 4'b1101, 16'd2, 16'd1);
        vecs[23] = mk(4'b1000, 32'h0, 32'h4, 32'h0, 8'hF8, 4'b1101, 16'd2, 16'd1);
        vecs[24] = mk(4'b0000, 32'h0, 32'h8, 32'h4, 8'hFC, 4'b1101, 16'd2, 16'd1);

        rst_n = 1'b0;
        drive(4'b0000, 32'h0);
        icache_rdata = 32'h0;
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].ctl, vecs[i].tgt);
            tick();
            check({tag, " addr"}, icache_addr, vecs[i].addr);
            check({tag, " valid_1"}, 32'(valid_1), 32'(vecs[i].flg[3]));
            check({tag, " instr_1"}, instr_1, vecs[i].flg[3] ? rom(vecs[i].pc1) : NOP);
            if (vecs[i].flg[3]) check({tag, " pc_1"}, pc_1, vecs[i].pc1);
            check({tag, " valid_3"}, 32'(valid_3), 32'(vecs[i].flg[2]));
            if (vecs[i].flg[2]) check({tag, " pc_3"}, 32'(pc_3), 32'(vecs[i].pc3));
            check({tag, " pred_taken_3"}, 32'(pred_taken_3), 32'(vecs[i].flg[1]));
            check({tag, " req"}, 32'(icache_req), 32'(vecs[i].flg[0]));
            check({tag, " flush_cnt"}, 32'(flush_cnt), 32'(vecs[i].fc));
            check({tag, " pred_cnt"}, 32'(pred_cnt), 32'(vecs[i].pcn));
        end

        // Flushes during a 3-cycle I-cache stall: latest target wins once the stall drops.
        drive(4'b1010, 32'h100);
        tick();
        check("stall1 addr", icache_addr, 32'h8);
        check("stall1 req", 32'(icache_req), 32'd0);
        check("stall1 valid_1", 32'(valid_1), 32'd0);
        check("stall1 valid_3", 32'(valid_3), 32'd0);
        drive(4'b1010, 32'h200);
        tick();
        check("stall2 addr", icache_addr, 32'h8);
        check("stall2 req", 32'(icache_req), 32'd0);
        drive(4'b1000, 32'h0);
        tick();
        check("stall3 addr", icache_addr, 32'h8);
        check("stall3 req", 32'(icache_req), 32'd0);
        drive(4'b0000, 32'h0);
        tick();
        check("redir addr", icache_addr, 32'h200);
        check("redir req", 32'(icache_req), 32'd1);
        check("redir valid_1", 32'(valid_1), 32'd0);
        check("redir flush_cnt", 32'(flush_cnt), 32'd3);
        tick();
        check("post addr", icache_addr, 32'h204);
        check("post valid_1", 32'(valid_1), 32'd1);
        check("post pc_1", pc_1, 32'h200);
        check("post instr_1", instr_1, rom(32'h200));

        // Reset while a redirect is pending discards it.
        drive(4'b1010, 32'h300);
        tick();
        check("pend req", 32'(icache_req), 32'd0);
        drive(4'b0000, 32'h0);
        rst_n = 1'b0;
        tick();
        check_reset("midrst");
        rst_n = 1'b1;
        tick();
        check("after rst addr", icache_addr, 32'h4);
        check("after rst valid_1", 32'(valid_1), 32'd1);
        check("after rst pc_1", pc_1, 32'h0);
        check("after rst req", 32'(icache_req), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
